cam_learn_ctrl: RTL and testbench

Controller that serialises learn (insert) and delete requests from `NUM_REQ` requesters onto a single block-RAM CAM write/compare interface. It checks for duplicates, allocates free slots, and tracks which CAM entries are in use. Each request ends with a one-cycle response pulse. The block sits directly in front of the CAM instance and owns the CAM's write port and compare port.

---
 rtl/cam_learn_ctrl_pkg.sv | 20 ++
 rtl/cam_learn_ctrl_if.sv | 40 ++++
 rtl/cam_learn_ctrl_rr_arbiter.sv | 57 +++++
 rtl/cam_learn_ctrl.sv | 159 +++++++++++++++
 tb/tb_cam_learn_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_learn_ctrl_pkg.sv
// Shared types for the CAM learn/delete controller: FSM state and response status codes.
package cam_learn_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_EVAL   = 3'd2,
    S_WRITE  = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ST_NEW      = 2'd0,
    ST_EXISTS   = 2'd1,
    ST_FULL     = 2'd2,
    ST_NOTFOUND = 2'd3
  } status_e;

endpackage

// File: rtl/cam_learn_ctrl_if.sv
// Request/response and CAM write/compare signals of the learn controller.
interface cam_learn_ctrl_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_op;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_key;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rsp_valid;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic [1:0]                    rsp_status;
  logic [ADDR_WIDTH-1:0]         rsp_addr;
  logic [ADDR_WIDTH:0]           entry_count;
  logic [ADDR_WIDTH-1:0]         cam_write_addr;
  logic [DATA_WIDTH-1:0]         cam_write_data;
  logic                          cam_write_delete;
  logic                          cam_write_enable;
  logic                          cam_write_busy;
  logic [DATA_WIDTH-1:0]         cam_compare_data;
  logic                          cam_match;
  logic [ADDR_WIDTH-1:0]         cam_match_addr;

  modport slave (
    input  req_valid, req_op, req_key, cam_write_busy, cam_match, cam_match_addr,
    output req_ready, rsp_valid, rsp_id, rsp_status, rsp_addr, entry_count,
           cam_write_addr, cam_write_data, cam_write_delete, cam_write_enable,
           cam_compare_data
  );

  modport master (
    output req_valid, req_op, req_key, cam_write_busy, cam_match, cam_match_addr,
    input  req_ready, rsp_valid, rsp_id, rsp_status, rsp_addr, entry_count,
           cam_write_addr, cam_write_data, cam_write_delete, cam_write_enable,
           cam_compare_data
  );
endinterface

// File: rtl/cam_learn_ctrl_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; pointer moves past the winner on each grant.
module cam_learn_ctrl_rr_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                en,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                grant_any
);

  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [ID_WIDTH-1:0] ID_ONE   = ID_WIDTH'(1);

  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] hi_idx, lo_idx;
  logic                hi_any, lo_any;

  // Lowest requester at/after the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_any = 1'b1;
        lo_idx = ID_WIDTH'(i);
        if (ID_WIDTH'(i) >= ptr) begin
          hi_any = 1'b1;
          hi_idx = ID_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    grant_any = en && lo_any;
    grant_idx = hi_any ? hi_idx : lo_idx;
    grant     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = grant_any && (grant_idx == ID_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + ID_ONE;
    end
  end

endmodule

// File: rtl/cam_learn_ctrl.sv
// Serialises learn/delete requests onto one CAM: duplicate check, free-slot allocation,
// occupancy bitmap and entry count, one response pulse per request.
module cam_learn_ctrl
  import cam_learn_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  cam_learn_ctrl_if.slave bus
);

  localparam int ID_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_ENTRIES = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  state_e                  state, state_nxt;
  logic [NUM_ENTRIES-1:0]  bitmap;
  logic [ADDR_WIDTH:0]     count;
  logic [DATA_WIDTH-1:0]   cmp_q, key_q, key_sel;
  logic                    op_q, op_sel;
  logic [ID_WIDTH-1:0]     id_q, gnt_idx;
  logic [ADDR_WIDTH-1:0]   addr_q, eval_addr;
  status_e                 status_q, eval_status;
  logic                    eval_write;
  logic [NUM_REQ-1:0]      gnt;
  logic                    gnt_any, arb_en, write_fire;
  logic [ADDR_WIDTH:0]     free_slot;

  // {found, index} of the lowest clear bit; found=0 means every slot is occupied.
  function automatic logic [ADDR_WIDTH:0] first_free(input logic [NUM_ENTRIES-1:0] map);
    logic [ADDR_WIDTH:0] r;
    r = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!map[i]) r = {1'b1, ADDR_WIDTH'(i)};
    end
    return r;
  endfunction

  assign arb_en     = (state == S_IDLE) && !bus.cam_write_busy;
  assign write_fire = (state == S_WRITE) && !bus.cam_write_busy;
  assign free_slot  = first_free(bitmap);

  cam_learn_ctrl_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .en        (arb_en),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  always_comb begin
    key_sel = '0;
    op_sel  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_WIDTH'(i)) begin
        key_sel = bus.req_key[i*DATA_WIDTH +: DATA_WIDTH];
        op_sel  = bus.req_op[i];
      end
    end
  end

  // Lookup outcome; a delete hit reports the NEW code with the freed slot.
  always_comb begin
    eval_status = ST_NEW;
    eval_addr   = '0;
    eval_write  = 1'b0;
    if (!op_q) begin
      if (bus.cam_match) begin
        eval_status = ST_EXISTS;
        eval_addr   = bus.cam_match_addr;
      end else if (!free_slot[ADDR_WIDTH]) begin
        eval_status = ST_FULL;
      end else begin
        eval_addr  = free_slot[ADDR_WIDTH-1:0];
        eval_write = 1'b1;
      end
    end else if (bus.cam_match) begin
      eval_addr  = bus.cam_match_addr;
      eval_write = 1'b1;
    end else begin
      eval_status = ST_NOTFOUND;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (gnt_any) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = S_EVAL;
      S_EVAL:   state_nxt = eval_write ? S_WRITE : S_RESP;
      S_WRITE:  if (write_fire) state_nxt = S_WAIT;
      S_WAIT:   if (!bus.cam_write_busy) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready        = gnt;
    bus.rsp_valid        = 1'b0;
    bus.rsp_id           = '0;
    bus.rsp_status       = '0;
    bus.rsp_addr         = '0;
    bus.cam_write_enable = 1'b0;
    bus.cam_write_addr   = '0;
    bus.cam_write_data   = '0;
    bus.cam_write_delete = 1'b0;
    if (state == S_RESP) begin
      bus.rsp_valid  = 1'b1;
      bus.rsp_id     = id_q;
      bus.rsp_status = status_q;
      bus.rsp_addr   = addr_q;
    end
    if (write_fire) begin
      bus.cam_write_enable = 1'b1;
      bus.cam_write_addr   = addr_q;
      bus.cam_write_data   = key_q;
      bus.cam_write_delete = op_q;
    end
  end

  assign bus.entry_count      = count;
  assign bus.cam_compare_data = cmp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      bitmap <= '0;
      count  <= '0;
      cmp_q  <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_any) cmp_q <= key_sel;
      if (write_fire) begin
        bitmap[addr_q] <= !op_q;
        count          <= op_q ? count - CNT_ONE : count + CNT_ONE;
      end
    end
  end

  // Request payload and lookup result; only observed through state-gated outputs.
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      key_q <= key_sel;
      op_q  <= op_sel;
      id_q  <= gnt_idx;
    end
    if (state == S_EVAL) begin
      addr_q   <= eval_addr;
      status_q <= eval_status;
    end
  end

endmodule

// File: tb/tb_cam_learn_ctrl.sv
// Directed bench for cam_learn_ctrl with a behavioural block-RAM CAM model.
module tb_cam_learn_ctrl;

  localparam int NR = 2;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NE = 1 << AW;

  localparam logic [1:0] NEW_C = 2'd0, EXISTS_C = 2'd1, FULL_C = 2'd2, NOTFOUND_C = 2'd3;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   we_count = 0;
  int   rsp_count = 0;
  logic [AW-1:0] we_addr;
  logic          we_del;

  cam_learn_ctrl_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cam_learn_ctrl #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CAM model: registered compare, write busy 4 cycles (learn) / 2 (delete), 8-cycle init.
  logic [DW-1:0] cam_mem [NE];
  logic [NE-1:0] cam_vld;
  int            busy_cnt;
  logic          hit;
  logic [AW-1:0] hit_addr;

  always_comb begin
    hit = 1'b0;
    hit_addr = '0;
    for (int i = NE - 1; i >= 0; i--) begin
      if (cam_vld[i] && cam_mem[i] == bus.cam_compare_data) begin
        hit = 1'b1;
        hit_addr = AW'(i);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_vld <= '0;
      busy_cnt <= 8;
      bus.cam_match <= 1'b0;
      bus.cam_match_addr <= '0;
    end else begin
      bus.cam_match <= hit;
      bus.cam_match_addr <= hit_addr;
      if (bus.cam_write_enable) begin
        if (bus.cam_write_delete) cam_vld[bus.cam_write_addr] <= 1'b0;
        else begin
          cam_vld[bus.cam_write_addr] <= 1'b1;
          cam_mem[bus.cam_write_addr] <= bus.cam_write_data;
        end
        busy_cnt <= bus.cam_write_delete ? 2 : 4;
      end else if (busy_cnt > 0) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end
  assign bus.cam_write_busy = (busy_cnt != 0);

  always @(negedge clk) begin
    if (bus.rsp_valid) rsp_count++;
    if (bus.cam_write_enable) begin
      we_count++;
      we_addr = bus.cam_write_addr;
      we_del  = bus.cam_write_delete;
      checks++;
      if (bus.cam_write_busy) begin
        errors++;
        $display("FAIL write_while_busy: enable=1 busy=%0b required busy=0", bus.cam_write_busy);
      end
    end
  end

  task automatic wait_init();
    int t;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!bus.cam_write_busy) break;
    end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL init_timeout: busy still %0b required 0", bus.cam_write_busy);
    end
  endtask

  task automatic do_req(input int id, input logic op, input logic [DW-1:0] key,
                        output logic [1:0] st, output logic [AW-1:0] ad, output int rid,
                        output int lat, output int nwr, output logic ok);
    int a;
    int w0;
    ok = 1'b0; st = '0; ad = '0; rid = -1; lat = -1; nwr = 0; a = -1;
    @(negedge clk);
    bus.req_key[id*DW +: DW] = key;
    bus.req_op[id] = op;
    bus.req_valid[id] = 1'b1;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (bus.req_ready[id]) begin a = cyc; break; end
      @(negedge clk);
    end
    w0 = we_count;
    if (a >= 0) begin
      @(posedge clk);
      #1;
      bus.req_valid[id] = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        #1;
        if (bus.rsp_valid) begin
          ok = 1'b1; st = bus.rsp_status; ad = bus.rsp_addr;
          rid = int'(bus.rsp_id); lat = cyc - a;
          break;
        end
      end
    end
    bus.req_valid[id] = 1'b0;
    nwr = we_count - w0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_timeout: id=%0d no response (grant cycle %0d) required a response", id, a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cam_write_enable !== 1'b0 || bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_strobes: rsp_valid=%0b we=%0b ready=%b required 0/0/00",
               bus.rsp_valid, bus.cam_write_enable, bus.req_ready);
    end
    checks++;
    if (bus.entry_count !== 6'd0 || bus.cam_compare_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_regs: count=%0d cmp=%h required 0/0", bus.entry_count, bus.cam_compare_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_key = {64'h77, 64'h66};
    bus.req_valid = 2'b11;
    repeat (4) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.req_ready !== 2'b00) begin
        errors++;
        $display("FAIL grant_during_init: ready=%b required 00", bus.req_ready);
      end
    end
    bus.req_valid = 2'b00;
    wait_init();
  endtask

  task automatic test_learn_new();
    logic [1:0] st; logic [AW-1:0] ad; int rid, lat, nwr; logic ok;
    do_req(0, 1'b0, 64'h1234, st, ad, rid, lat, nwr, ok);
    checks++;
    if (st !== NEW_C || ad !== 5'd0 || rid != 0) begin
      errors++;
      $display("FAIL learn_new: st=%0d addr=%0d id=%0d required 0/0/0", st, ad, rid);
    end
    checks++;
    if (lat != 9) begin errors++; $display("FAIL learn_new_latency: %0d required 9", lat); end
    checks++;
    if (nwr != 1 || we_addr !== 5'd0 || we_del !== 1'b0) begin
      errors++;
      $display("FAIL learn_new_write: n=%0d addr=%0d del=%0b required 1/0/0", nwr, we_addr, we_del);
    end
    checks++;
    if (bus.entry_count !== 6'd1) begin
      errors++; $display("FAIL learn_new_count: %0d required 1", bus.entry_count);
    end
  endtask

  task automatic test_learn_exists();
    logic [1:0] st; logic [AW-1:0] ad; int rid, lat, nwr; logic ok;
    do_req(1, 1'b0, 64'h1234, st, ad, rid, lat, nwr, ok);
    checks++;
    if (st !== EXISTS_C || ad !== 5'd0 || rid != 1) begin
      errors++;
      $display("FAIL learn_exists: st=%0d addr=%0d id=%0d required 1/0/1", st, ad, rid);
    end
    checks++;
    if (lat != 3 || nwr != 0) begin
      errors++; $display("FAIL learn_exists_timing: lat=%0d writes=%0d required 3/0", lat, nwr);
    end
    checks++;
    if (bus.entry_count !== 6'd1) begin
      errors++; $display("FAIL learn_exists_count: %0d required 1", bus.entry_count);
    end
  endtask

  task automatic test_fill_rr();
    int n0, n1, gcount, rcount, t;
    logic [1:0] pend;
    n0 = 0; n1 = 0; gcount = 0; rcount = 0; pend = 2'b00;
    @(negedge clk);
    bus.req_key = {64'hB000, 64'hA000};
    bus.req_op = 2'b00;
    bus.req_valid = 2'b11;
    for (t = 0; t < 1500 && rcount < NE; t++) begin
      #1;
      if (bus.req_ready !== 2'b00) begin
        checks++;
        if (bus.req_ready !== ((gcount % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL rr_order: grant %0d ready=%b required %b", gcount, bus.req_ready,
                   (gcount % 2 == 0) ? 2'b01 : 2'b10);
        end
        pend = bus.req_ready;
        gcount++;
      end
      if (bus.rsp_valid) begin
        checks++;
        if (rcount < NE - 1) begin
          if (bus.rsp_status !== NEW_C || bus.rsp_addr !== AW'(rcount + 1)) begin
            errors++;
            $display("FAIL fill_new: rsp %0d st=%0d addr=%0d required 0/%0d", rcount,
                     bus.rsp_status, bus.rsp_addr, rcount + 1);
          end
        end else if (bus.rsp_status !== FULL_C || bus.rsp_addr !== 5'd0) begin
          errors++;
          $display("FAIL fill_full: st=%0d addr=%0d required 2/0", bus.rsp_status, bus.rsp_addr);
        end
        rcount++;
        if (rcount == NE) bus.req_valid = 2'b00;
      end
      @(negedge clk);
      if (pend[0]) begin n0++; bus.req_key[63:0]   = 64'hA000 + 64'(n0); end
      if (pend[1]) begin n1++; bus.req_key[127:64] = 64'hB000 + 64'(n1); end
      pend = 2'b00;
    end
    bus.req_valid = 2'b00;
    checks++;
    if (rcount < NE) begin
      errors++; $display("FAIL fill_timeout: %0d responses required %0d", rcount, NE);
    end
    checks++;
    if (bus.entry_count !== 6'd32) begin
      errors++; $display("FAIL fill_count: %0d required 32", bus.entry_count);
    end
  endtask

  task automatic test_delete_relearn();
    logic [1:0] st; logic [AW-1:0] ad; int rid, lat, nwr; logic ok;
    do_req(0, 1'b1, 64'hA001, st, ad, rid, lat, nwr, ok);
    checks++;
    if (st !== NEW_C || ad !== 5'd3 || lat != 7) begin
      errors++;
      $display("FAIL delete_hit: st=%0d addr=%0d lat=%0d required 0/3/7", st, ad, lat);
    end
    checks++;
    if (nwr != 1 || we_del !== 1'b1 || we_addr !== 5'd3) begin
      errors++;
      $display("FAIL delete_write: n=%0d del=%0b addr=%0d required 1/1/3", nwr, we_del, we_addr);
    end
    checks++;
    if (bus.entry_count !== 6'd31) begin
      errors++; $display("FAIL delete_count: %0d required 31", bus.entry_count);
    end
    do_req(1, 1'b0, 64'hC0DE, st, ad, rid, lat, nwr, ok);
    checks++;
    if (st !== NEW_C || ad !== 5'd3 || lat != 9 || rid != 1) begin
      errors++;
      $display("FAIL relearn: st=%0d addr=%0d lat=%0d id=%0d required 0/3/9/1", st, ad, lat, rid);
    end
    checks++;
    if (bus.entry_count !== 6'd32) begin
      errors++; $display("FAIL relearn_count: %0d required 32", bus.entry_count);
    end
  endtask

  task automatic test_notfound();
    logic [1:0] st; logic [AW-1:0] ad; int rid, lat, nwr; logic ok;
    do_req(0, 1'b1, 64'hDEAD, st, ad, rid, lat, nwr, ok);
    checks++;
    if (st !== NOTFOUND_C || ad !== 5'd0 || lat != 3 || nwr != 0) begin
      errors++;
      $display("FAIL notfound: st=%0d addr=%0d lat=%0d writes=%0d required 3/0/3/0", st, ad, lat, nwr);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [1:0] st; logic [AW-1:0] ad; int rid, lat, nwr; logic ok;
    int r0, t;
    @(negedge clk);
    bus.req_key[127:64] = 64'hC0DE;
    bus.req_op[1] = 1'b1;
    bus.req_valid[1] = 1'b1;
    for (t = 0; t < 100; t++) begin
      #1;
      if (bus.req_ready[1]) break;
      @(negedge clk);
    end
    checks++;
    if (t >= 100) begin errors++; $display("FAIL mid_grant_timeout: ready=%b required 10", bus.req_ready); end
    r0 = rsp_count;
    repeat (5) @(posedge clk);
    #2;
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.entry_count !== 6'd0 || bus.rsp_valid !== 1'b0 || bus.cam_write_enable !== 1'b0 ||
        bus.cam_compare_data !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: count=%0d rsp=%0b we=%0b cmp=%h required all 0",
               bus.entry_count, bus.rsp_valid, bus.cam_write_enable, bus.cam_compare_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    checks++;
    if (rsp_count != r0) begin
      errors++; $display("FAIL mid_reset_dropped: %0d responses required 0", rsp_count - r0);
    end
    do_req(0, 1'b0, 64'h5555, st, ad, rid, lat, nwr, ok);
    checks++;
    if (st !== NEW_C || ad !== 5'd0 || lat != 9 || bus.entry_count !== 6'd1) begin
      errors++;
      $display("FAIL post_reset_learn: st=%0d addr=%0d lat=%0d count=%0d required 0/0/9/1",
               st, ad, lat, bus.entry_count);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_key   = '0;
    test_reset();
    test_learn_new();
    test_learn_exists();
    test_fill_rr();
    test_delete_relearn();
    test_notfound();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
